// File: rtl/ddr_init.sv
// DDR SDRAM power-up initialisation sequencer: drives the JEDEC init command
// sequence on the command pins, then raises init_done and parks on NOP.
module ddr_init #(
  parameter int BA_BITS   = 2,
  parameter int ROW_BITS  = 13,
  parameter int PWR_CYC   = 20000,
  parameter int T_RP_CYC  = 3,
  parameter int T_MRD_CYC = 2,
  parameter int T_RFC_CYC = 8,
  parameter int DLL_CYC   = 200,
  parameter logic [ROW_BITS-1:0] MR_VAL  = 'h0021,
  parameter logic [ROW_BITS-1:0] EMR_VAL = 'h0000
) (
  input  logic                core_clk,
  input  logic                core_rstn_sync,
  output logic                ddr_cke,
  output logic                ddr_cs_n,
  output logic                ddr_ras_n,
  output logic                ddr_cas_n,
  output logic                ddr_we_n,
  output logic [BA_BITS-1:0]  ddr_ba,
  output logic [ROW_BITS-1:0] ddr_a,
  output logic                init_done
);

  localparam int CW = ($clog2(PWR_CYC + 1) > 16) ? $clog2(PWR_CYC + 1) : 16;
  localparam logic [CW-1:0] PWR_W = CW'(PWR_CYC);
  localparam logic [CW-1:0] RP_W  = CW'(T_RP_CYC);
  localparam logic [CW-1:0] MRD_W = CW'(T_MRD_CYC);
  localparam logic [CW-1:0] RFC_W = CW'(T_RFC_CYC);
  localparam logic [CW-1:0] DLL_W = CW'(DLL_CYC);
  localparam logic [ROW_BITS-1:0] BIT8  = ROW_BITS'(1) << 8;
  localparam logic [ROW_BITS-1:0] BIT10 = ROW_BITS'(1) << 10;

  localparam logic [3:0] CMD_DES = 4'b1111;
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  typedef enum logic [3:0] {
    S_PWR, S_CKE, S_PRE1, S_EMR, S_MRDLL, S_PRE2, S_REF1, S_REF2, S_MR, S_DONE
  } state_e;

  state_e              state_q, state_d, nxt;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ent_d, adv;
  logic                cke_q, cke_d, done_q, done_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [BA_BITS-1:0]  ba_q, ba_d;
  logic [ROW_BITS-1:0] a_q, a_d;

  function automatic logic [CW-1:0] wait_of(input state_e s);
    case (s)
      S_PRE1, S_PRE2: return RP_W;
      S_EMR, S_MR:    return MRD_W;
      S_MRDLL:        return DLL_W;
      S_REF1, S_REF2: return RFC_W;
      default:        return '0;
    endcase
  endfunction

  always_ff @(posedge core_clk or negedge core_rstn_sync) begin
    if (!core_rstn_sync) begin
      state_q <= S_PWR;
      cnt_q   <= PWR_W;
      cke_q   <= 1'b0;
      cmd_q   <= CMD_DES;
      ba_q    <= '0;
      a_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cke_q   <= cke_d;
      cmd_q   <= cmd_d;
      ba_q    <= ba_d;
      a_q     <= a_d;
      done_q  <= done_d;
    end
  end

  // Command states spend the entry cycle on the command, then count the wait
  // down to 0. The power-up counter instead holds cycles left including this one.
  always_comb begin
    nxt = S_DONE;
    case (state_q)
      S_PWR:   nxt = S_CKE;
      S_CKE:   nxt = S_PRE1;
      S_PRE1:  nxt = S_EMR;
      S_EMR:   nxt = S_MRDLL;
      S_MRDLL: nxt = S_PRE2;
      S_PRE2:  nxt = S_REF1;
      S_REF1:  nxt = S_REF2;
      S_REF2:  nxt = S_MR;
      default: nxt = S_DONE;
    endcase
    if (state_q == S_PWR) adv = (cnt_q <= CW'(1));
    else                  adv = (state_q != S_DONE) && (cnt_q == '0);
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
    ent_d   = 1'b0;
    if (adv) begin
      state_d = nxt;
      cnt_d   = wait_of(nxt);
      ent_d   = 1'b1;
    end
  end

  // Outputs are decoded from the next state so the pins line up with state_q.
  always_comb begin
    cke_d  = 1'b1;
    cmd_d  = CMD_NOP;
    ba_d   = '0;
    a_d    = '0;
    done_d = 1'b0;
    case (state_d)
      S_PWR: begin
        cke_d = 1'b0;
        cmd_d = CMD_DES;
      end
      S_PRE1, S_PRE2: if (ent_d) begin
        cmd_d = CMD_PRE;
        a_d   = BIT10;
      end
      S_EMR: if (ent_d) begin
        cmd_d = CMD_LMR;
        ba_d  = BA_BITS'(1);
        a_d   = EMR_VAL;
      end
      S_MRDLL: if (ent_d) begin
        cmd_d = CMD_LMR;
        a_d   = MR_VAL | BIT8;
      end
      S_REF1, S_REF2: if (ent_d) cmd_d = CMD_REF;
      S_MR: if (ent_d) begin
        cmd_d = CMD_LMR;
        a_d   = MR_VAL & ~BIT8;
      end
      S_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  assign ddr_cke = cke_q;
  assign {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n} = cmd_q;
  assign ddr_ba    = ba_q;
  assign ddr_a     = a_q;
  assign init_done = done_q;

endmodule
